// File: rtl/arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq_if.sv
// arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq_if: BCAM MBIST sequencer bus.
// master = sequencer side (drives RF strobes and status).
// slave  = RF/controller side (drives start, inv_cfg, cm_hit_in).
interface arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq_if #(
  parameter int RF_DWIDTH = 72,
  parameter int RF_DEPTH  = 192,
  parameter int AWIDTH    = 8,
  parameter int BWIDTH    = 7
) ();
  logic                 bist_start;
  logic                 bist_inv_cfg;
  logic [RF_DEPTH-1:0]  cm_hit_in;
  logic                 BIST_WR_EN_RF_OUT;
  logic [AWIDTH-1:0]    BIST_WR_ADDR_RF_OUT;
  logic [RF_DWIDTH-1:0] BIST_WR_DATA_RF_OUT;
  logic                 BIST_CM_EN_RF_OUT;
  logic                 BIST_CM_MODE_RF_OUT;
  logic                 BIST_CD_MASK_ENABLE_RF_OUT;
  logic                 BIST_ROTATE_MASK_RF_OUT;
  logic                 BIST_DATA_INV_RF_OUT;
  logic                 bist_busy;
  logic                 bist_done;
  logic                 bist_fail;
  logic [AWIDTH-1:0]    bist_fail_addr;
  logic [BWIDTH-1:0]    bist_fail_bit;
  modport master (
    input  bist_start, bist_inv_cfg, cm_hit_in,
    output BIST_WR_EN_RF_OUT, BIST_WR_ADDR_RF_OUT, BIST_WR_DATA_RF_OUT,
           BIST_CM_EN_RF_OUT, BIST_CM_MODE_RF_OUT, BIST_CD_MASK_ENABLE_RF_OUT,
           BIST_ROTATE_MASK_RF_OUT, BIST_DATA_INV_RF_OUT,
           bist_busy, bist_done, bist_fail, bist_fail_addr, bist_fail_bit
  );
  modport slave (
    output bist_start, bist_inv_cfg, cm_hit_in,
    input  BIST_WR_EN_RF_OUT, BIST_WR_ADDR_RF_OUT, BIST_WR_DATA_RF_OUT,
           BIST_CM_EN_RF_OUT, BIST_CM_MODE_RF_OUT, BIST_CD_MASK_ENABLE_RF_OUT,
           BIST_ROTATE_MASK_RF_OUT, BIST_DATA_INV_RF_OUT,
           bist_busy, bist_done, bist_fail, bist_fail_addr, bist_fail_bit
  );
endinterface

// File: rtl/arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq.sv
// arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq: BCAM MBIST sequencer.
// Writes an all-zero background to every entry, does one unmasked compare
// (all entries must hit), then walks a one-hot compare mask over every data
// bit (no entry may hit). First failure (entry, bit) is captured; run continues.
// Ports: bist_clk (clock), rst_b (async active-low reset), bus (master modport:
// start/inv_cfg/cm_hit_in in; RF write/compare strobes and status out).
module arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq #(
  parameter int RF_DWIDTH = 72,
  parameter int RF_DEPTH  = 192,
  parameter int AWIDTH    = 8,
  parameter int BWIDTH    = 7
) (
  input logic bist_clk,
  input logic rst_b,
  arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, CMP_BG, WAIT_BG, CMP_WALK, WAIT_WALK, ROTATE, DONE} state_t;
  localparam logic [AWIDTH-1:0] LAST_A = AWIDTH'(RF_DEPTH - 1);
  localparam logic [BWIDTH-1:0] LAST_B = BWIDTH'(RF_DWIDTH - 1);
  state_t state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d, first;
  logic [BWIDTH-1:0] bit_q, bit_d;
  logic wr_en_q, wr_en_d, cm_en_q, cm_en_d, cm_mode_q, cm_mode_d, mask_en_q, mask_en_d;
  logic rot_q, rot_d, inv_q, inv_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d, fail_addr_q, fail_addr_d;
  logic [BWIDTH-1:0] fail_bit_q, fail_bit_d;
  logic start_ok, wait_bg, in_wait, capture;
  logic [RF_DEPTH-1:0] mm;
  assign start_ok = (state_q == IDLE || state_q == DONE) && bus.bist_start;
  assign wait_bg  = state_q == WAIT_BG;
  assign in_wait  = wait_bg || state_q == WAIT_WALK;
  // Background phase expects every entry to hit, walk phase expects none.
  assign mm       = wait_bg ? ~bus.cm_hit_in : bus.cm_hit_in;
  assign capture  = in_wait && |mm && !fail_q;
  // Lowest mismatching entry index.
  always_comb begin
    first = '0;
    for (int i = RF_DEPTH - 1; i >= 0; i--) if (mm[i]) first = AWIDTH'(i);
  end
  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      bit_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      cm_en_q     <= 1'b0;
      cm_mode_q   <= 1'b0;
      mask_en_q   <= 1'b0;
      rot_q       <= 1'b0;
      inv_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_bit_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bit_q       <= bit_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      cm_en_q     <= cm_en_d;
      cm_mode_q   <= cm_mode_d;
      mask_en_q   <= mask_en_d;
      rot_q       <= rot_d;
      inv_q       <= inv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_bit_q  <= fail_bit_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE, DONE: if (start_ok) begin
        state_d = WRITE;
        addr_d  = '0;
        bit_d   = '0;
      end
      WRITE:     if (addr_q == LAST_A) state_d = CMP_BG; else addr_d = addr_q + 1'b1;
      CMP_BG:    state_d = WAIT_BG;
      WAIT_BG:   state_d = CMP_WALK;
      CMP_WALK:  state_d = WAIT_WALK;
      WAIT_WALK: state_d = ROTATE;
      ROTATE:    if (bit_q == LAST_B) state_d = DONE; else begin
        state_d = CMP_WALK;
        bit_d   = bit_q + 1'b1;
      end
      default:   state_d = IDLE;
    endcase
  end
  // Outputs are decoded from next state so every output comes straight from a flop.
  always_comb begin
    wr_en_d     = state_d == WRITE;
    wr_addr_d   = addr_d;
    cm_en_d     = state_d == CMP_BG || state_d == CMP_WALK;
    cm_mode_d   = !(state_d == IDLE || state_d == WRITE || state_d == DONE);
    mask_en_d   = state_d == CMP_WALK || state_d == WAIT_WALK;
    rot_d       = state_d == ROTATE;
    busy_d      = cm_mode_d || wr_en_d;
    done_d      = state_d == DONE;
    inv_d       = start_ok ? bus.bist_inv_cfg : inv_q;
    fail_d      = start_ok ? 1'b0 : fail_q || (in_wait && |mm);
    fail_addr_d = start_ok ? '0 : capture ? first : fail_addr_q;
    fail_bit_d  = start_ok ? '0 : capture ? (wait_bg ? '1 : bit_q) : fail_bit_q;
  end
  assign bus.BIST_WR_EN_RF_OUT          = wr_en_q;
  assign bus.BIST_WR_ADDR_RF_OUT        = wr_addr_q;
  assign bus.BIST_WR_DATA_RF_OUT        = '0;
  assign bus.BIST_CM_EN_RF_OUT          = cm_en_q;
  assign bus.BIST_CM_MODE_RF_OUT        = cm_mode_q;
  assign bus.BIST_CD_MASK_ENABLE_RF_OUT = mask_en_q;
  assign bus.BIST_ROTATE_MASK_RF_OUT    = rot_q;
  assign bus.BIST_DATA_INV_RF_OUT       = inv_q;
  assign bus.bist_busy                  = busy_q;
  assign bus.bist_done                  = done_q;
  assign bus.bist_fail                  = fail_q;
  assign bus.bist_fail_addr             = fail_addr_q;
  assign bus.bist_fail_bit              = fail_bit_q;
endmodule

// File: tb/tb_arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq.sv
// tb_arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq: scoreboard bench for the BCAM MBIST sequencer.
module tb_arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq;
  localparam int D = 192;
  localparam int W = 72;
  typedef struct packed {
    logic [3:0]  k;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;
  } ev_t;
  localparam logic [3:0] K_RST = 4'd0, K_WR = 4'd1, K_CMB = 4'd2, K_CMW = 4'd3, K_ROT = 4'd4, K_DONE = 4'd5;
  logic bist_clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 bist_clk = ~bist_clk;
  arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq_if #(.RF_DWIDTH(W), .RF_DEPTH(D), .AWIDTH(8), .BWIDTH(7)) bif ();
  arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_seq #(.RF_DWIDTH(W), .RF_DEPTH(D), .AWIDTH(8), .BWIDTH(7)) u_dut (
    .bist_clk(bist_clk),
    .rst_b(rst_b),
    .bus(bif)
  );
  ev_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int bg_fault = -1;
  logic [D-1:0] walk_fault [W];
  function automatic ev_t mk(input logic [3:0] k, input int a, input int b, input int c);
    return '{k: k, a: 16'(a), b: 16'(b), c: 32'(c)};
  endfunction
  task automatic check(input ev_t got);
    ev_t exp;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got k=%0d a=%0d b=%0h c=%0d, required no event", got.k, got.a, got.b, got.c);
    end else begin
      exp = q.pop_front();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL event_k%0d: got k=%0d a=%0d b=%0h c=%0d, required k=%0d a=%0d b=%0h c=%0d",
                 exp.k, got.k, got.a, got.b, got.c, exp.k, exp.a, exp.b, exp.c);
      end
    end
  endtask
  // Ideal CAM: background compare hits everywhere, walking compare hits nowhere;
  // planted faults override; outside the wait cycle the hit vector is garbage.
  logic [D-1:0] hit_m;
  int wcnt = 0;
  logic pcm = 1'b0;
  always @(negedge bist_clk) begin
    if (bif.BIST_CM_EN_RF_OUT) begin
      if (!bif.BIST_CD_MASK_ENABLE_RF_OUT) begin
        hit_m = '1;
        if (bg_fault >= 0) hit_m[bg_fault] = 1'b0;
        wcnt = 0;
      end else begin
        hit_m = (wcnt < W) ? walk_fault[wcnt] : '0;
        wcnt = wcnt + 1;
      end
      pcm = 1'b1;
    end else begin
      if (!pcm) hit_m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pcm = 1'b0;
    end
    bif.cm_hit_in = hit_m;
  end
  // Monitor: turns DUT activity into events and checks them against the queue.
  int cnt = 0, wc = 0, rc = 0;
  logic pb = 1'b0, pd = 1'b0, pr = 1'b1;
  logic [2:0] fl;
  always @(negedge bist_clk) begin
    fl = {bif.BIST_CM_MODE_RF_OUT, bif.BIST_CD_MASK_ENABLE_RF_OUT, bif.BIST_DATA_INV_RF_OUT};
    if (!rst_b) begin
      if (pr) check(mk(K_RST, {bif.BIST_WR_ADDR_RF_OUT, bif.bist_fail_addr},
                        {bif.BIST_WR_EN_RF_OUT, bif.BIST_CM_EN_RF_OUT, fl, bif.BIST_ROTATE_MASK_RF_OUT,
                         bif.bist_busy, bif.bist_done, bif.bist_fail, (|bif.BIST_WR_DATA_RF_OUT)},
                        int'(bif.bist_fail_bit)));
      pb = 1'b0;
      pd = 1'b0;
    end else begin
      cnt = (bif.bist_busy && !pb) ? 0 : cnt + 1;
      if (bif.BIST_WR_EN_RF_OUT) check(mk(K_WR, int'(bif.BIST_WR_ADDR_RF_OUT), {|bif.BIST_WR_DATA_RF_OUT, fl}, 0));
      if (bif.BIST_CM_EN_RF_OUT && !bif.BIST_CD_MASK_ENABLE_RF_OUT) begin
        wc = 0;
        rc = 0;
        check(mk(K_CMB, 0, int'(fl), 0));
      end
      if (bif.BIST_CM_EN_RF_OUT && bif.BIST_CD_MASK_ENABLE_RF_OUT) begin
        check(mk(K_CMW, wc, int'(fl), 0));
        wc++;
      end
      if (bif.BIST_ROTATE_MASK_RF_OUT) begin
        check(mk(K_ROT, rc, int'(fl), 0));
        rc++;
      end
      if (bif.bist_done && !pd)
        check(mk(K_DONE, int'(bif.bist_fail_addr), {bif.bist_fail, bif.bist_busy, bif.BIST_DATA_INV_RF_OUT, bif.bist_fail_bit}, cnt));
      pb = bif.bist_busy;
      pd = bif.bist_done;
    end
    pr = rst_b;
  end
  task automatic push_run(input logic inv, input logic f, input int fa, input logic [6:0] fb);
    for (int i = 0; i < D; i++) q.push_back(mk(K_WR, i, {1'b0, 1'b0, 1'b0, inv}, 0));
    q.push_back(mk(K_CMB, 0, {1'b1, 1'b0, inv}, 0));
    for (int k = 0; k < W; k++) begin
      q.push_back(mk(K_CMW, k, {1'b1, 1'b1, inv}, 0));
      q.push_back(mk(K_ROT, k, {1'b1, 1'b0, inv}, 0));
    end
    q.push_back(mk(K_DONE, fa, {f, 1'b0, inv, fb}, 410));
  endtask
  task automatic start(input logic inv);
    @(posedge bist_clk);
    #1 bif.bist_start = 1'b1;
    bif.bist_inv_cfg = inv;
    @(posedge bist_clk);
    #1 bif.bist_start = 1'b0;
    bif.bist_inv_cfg = ~inv;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!bif.bist_done && n < 500) begin
      @(posedge bist_clk);
      #1 n++;
    end
    if (!bif.bist_done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles, required done", name, n);
    end
    @(negedge bist_clk);
    #1 vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_leftover: got %0d unconsumed events, required 0", name, q.size());
    end
    q.delete();
  endtask
  initial begin
    bif.bist_start = 1'b0;
    bif.bist_inv_cfg = 1'b0;
    for (int k = 0; k < W; k++) walk_fault[k] = '0;
    q.push_back(mk(K_RST, 0, 0, 0));
    #2 rst_b = 1'b0;
    repeat (3) @(posedge bist_clk);
    #1 rst_b = 1'b1;
    // Clean run with a start pulse mid-run that must be ignored.
    push_run(1'b0, 1'b0, 0, 7'd0);
    start(1'b0);
    repeat (99) @(posedge bist_clk);
    #1 bif.bist_start = 1'b1;
    @(posedge bist_clk);
    #1 bif.bist_start = 1'b0;
    wait_done("clean");
    // Entry 5 misses the background compare.
    bg_fault = 5;
    push_run(1'b0, 1'b1, 5, 7'd127);
    start(1'b0);
    wait_done("bg_fault");
    bg_fault = -1;
    // Spurious walk hits: first failure at b=10, lowest entry 3; later b=20 ignored.
    walk_fault[10][100] = 1'b1;
    walk_fault[10][3] = 1'b1;
    walk_fault[20][7] = 1'b1;
    push_run(1'b0, 1'b1, 3, 7'd10);
    start(1'b0);
    wait_done("walk_fault");
    for (int k = 0; k < W; k++) walk_fault[k] = '0;
    // Restart from DONE with inverted data clears the previous failure.
    push_run(1'b1, 1'b0, 0, 7'd0);
    start(1'b1);
    wait_done("inv_run");
    // Reset mid-run, then a clean restart.
    push_run(1'b0, 1'b0, 0, 7'd0);
    start(1'b0);
    repeat (249) @(posedge bist_clk);
    #1 q.delete();
    q.push_back(mk(K_RST, 0, 0, 0));
    rst_b = 1'b0;
    @(posedge bist_clk);
    #1 rst_b = 1'b1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL midrun_reset: got %0d pending events, required 0", q.size());
    end
    push_run(1'b0, 1'b0, 0, 7'd0);
    start(1'b0);
    wait_done("restart");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
